// File: rtl/maple_rx_frame_ctrl.sv
// Maple bus receive frame sequencer: parses the header, buffers payload bytes, checks the
// XOR CRC and holds each frame result for the host behind a valid/ack handshake.
module maple_rx_frame_ctrl #(
  parameter int MAX_WORDS = 255,
  parameter int ADDR_W    = 10,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_busy,
  input  logic              rx_write,
  input  logic [7:0]        rx_data,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic [2:0]        frame_err,
  output logic [7:0]        hdr_cmd,
  output logic [7:0]        hdr_dst,
  output logic [7:0]        hdr_src,
  output logic [7:0]        hdr_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [7:0]        drop_count
);

  localparam int                TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]     TO_ONE    = TW'(1);
  localparam logic [7:0]        MAX_LEN   = 8'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [2:0] ERR_OK = 3'd0, ERR_CRC = 3'd1, ERR_SHORT = 3'd2,
                         ERR_LONG = 3'd3, ERR_OVF = 3'd4, ERR_TMO = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PAYLOAD, S_CRC, S_TAIL, S_ERR, S_DONE
  } state_t;

  state_t            state_r, next_state_s;
  logic [2:0]        next_err_s;
  logic              busy_prev_r;
  logic [ADDR_W-1:0] byte_cnt_r;
  logic [7:0]        word_cnt_r;
  logic [7:0]        crc_r;
  logic [TW-1:0]     timer_r;
  logic              frame_valid_r;
  logic [2:0]        frame_err_r;
  logic [7:0]        hdr_cmd_r, hdr_dst_r, hdr_src_r, hdr_len_r;
  logic [7:0]        rd_data_r;
  logic [7:0]        drop_count_r;
  logic [7:0]        mem [2**ADDR_W];
  logic              rise_s, active_s, last_byte_s, timeout_s;

  assign rise_s      = rx_busy & ~busy_prev_r;
  assign active_s    = (state_r == S_HDR) || (state_r == S_PAYLOAD) ||
                       (state_r == S_CRC) || (state_r == S_TAIL);
  assign last_byte_s = (byte_cnt_r[1:0] == 2'd3) && (word_cnt_r == hdr_len_r - 8'd1);
  assign timeout_s   = active_s && !rx_write && (timer_r == TO_LAST);

  // Next state: the byte of this cycle is applied first, then a falling rx_busy on top of it.
  always_comb begin
    next_state_s = state_r;
    next_err_s   = frame_err_r;
    case (state_r)
      S_IDLE: begin
        if (rise_s) begin
          next_state_s = S_HDR;
          next_err_s   = ERR_OK;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_HDR: begin
        if (rx_write && (byte_cnt_r[1:0] == 2'd3)) begin
          if (rx_data > MAX_LEN) begin
            next_state_s = S_ERR;
            next_err_s   = ERR_OVF;
          end else if (rx_data == 8'd0) begin
            next_state_s = S_CRC;
          end else begin
            next_state_s = S_PAYLOAD;
          end
        end else begin
          next_state_s = S_HDR;
        end
      end
      S_PAYLOAD: begin
        if (rx_write && last_byte_s) next_state_s = S_CRC;
        else                         next_state_s = S_PAYLOAD;
      end
      S_CRC: begin
        if (rx_write) begin
          if (rx_data == crc_r) begin
            next_state_s = S_TAIL;
          end else begin
            next_state_s = S_ERR;
            next_err_s   = ERR_CRC;
          end
        end else begin
          next_state_s = S_CRC;
        end
      end
      S_TAIL: begin
        if (rx_write) begin
          next_state_s = S_ERR;
          next_err_s   = ERR_LONG;
        end else begin
          next_state_s = S_TAIL;
        end
      end
      S_ERR:  next_state_s = S_ERR;
      S_DONE: begin
        if (frame_valid_r && frame_ack) next_state_s = S_IDLE;
        else                            next_state_s = S_DONE;
      end
      default: next_state_s = S_IDLE;
    endcase
    if (timeout_s) begin
      next_state_s = S_DONE;
      next_err_s   = ERR_TMO;
    end else if (!rx_busy && (active_s || (state_r == S_ERR))) begin
      case (next_state_s)
        S_TAIL: begin
          next_state_s = S_DONE;
          next_err_s   = ERR_OK;
        end
        S_ERR:   next_state_s = S_DONE;
        default: begin
          next_state_s = S_DONE;
          next_err_s   = ERR_SHORT;
        end
      endcase
    end else begin
      next_state_s = next_state_s;
    end
  end

  // Frame sequencer state, counters, CRC accumulator and host-facing result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      busy_prev_r   <= 1'b1;
      byte_cnt_r    <= ADDR_ZERO;
      word_cnt_r    <= 8'd0;
      crc_r         <= 8'd0;
      timer_r       <= {TW{1'b0}};
      frame_valid_r <= 1'b0;
      frame_err_r   <= 3'd0;
      hdr_cmd_r     <= 8'd0;
      hdr_dst_r     <= 8'd0;
      hdr_src_r     <= 8'd0;
      hdr_len_r     <= 8'd0;
      drop_count_r  <= 8'd0;
    end else begin
      state_r     <= next_state_s;
      frame_err_r <= next_err_s;
      busy_prev_r <= rx_busy;
      timer_r     <= (rx_write || !active_s) ? {TW{1'b0}} : timer_r + TO_ONE;
      case (state_r)
        S_IDLE: begin
          if (rise_s) begin
            byte_cnt_r <= ADDR_ZERO;
            word_cnt_r <= 8'd0;
            crc_r      <= 8'd0;
          end
        end
        S_HDR: begin
          if (rx_write) begin
            crc_r <= crc_r ^ rx_data;
            case (byte_cnt_r[1:0])
              2'd0:    hdr_cmd_r <= rx_data;
              2'd1:    hdr_dst_r <= rx_data;
              2'd2:    hdr_src_r <= rx_data;
              default: hdr_len_r <= rx_data;
            endcase
            byte_cnt_r <= (byte_cnt_r[1:0] == 2'd3) ? ADDR_ZERO : byte_cnt_r + ADDR_ONE;
          end
        end
        S_PAYLOAD: begin
          if (rx_write) begin
            crc_r      <= crc_r ^ rx_data;
            byte_cnt_r <= byte_cnt_r + ADDR_ONE;
            if (byte_cnt_r[1:0] == 2'd3) word_cnt_r <= word_cnt_r + 8'd1;
          end
        end
        S_DONE: begin
          if (!frame_valid_r)  frame_valid_r <= 1'b1;
          else if (frame_ack)  frame_valid_r <= 1'b0;
          if (rise_s && (drop_count_r != 8'd255)) drop_count_r <= drop_count_r + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Payload buffer: written only while receiving payload bytes.
  always_ff @(posedge clk) begin
    if ((state_r == S_PAYLOAD) && rx_write) mem[byte_cnt_r] <= rx_data;
  end

  // Registered host read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_r <= 8'd0;
    else        rd_data_r <= mem[rd_addr];
  end

  assign frame_valid = frame_valid_r;
  assign frame_err   = frame_err_r;
  assign hdr_cmd     = hdr_cmd_r;
  assign hdr_dst     = hdr_dst_r;
  assign hdr_src     = hdr_src_r;
  assign hdr_len     = hdr_len_r;
  assign rd_data     = rd_data_r;
  assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_maple_rx_frame_ctrl.sv
// Scoreboard bench for maple_rx_frame_ctrl: frames are driven byte by byte, the expected
// result is queued at send time and compared when the DUT raises frame_valid.
module tb_maple_rx_frame_ctrl;

  localparam int MAXW = 8;
  localparam int AW   = 10;
  localparam int TMO  = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_busy;
  logic          rx_write;
  logic [7:0]    rx_data;
  logic          frame_valid;
  logic          frame_ack;
  logic [2:0]    frame_err;
  logic [7:0]    hdr_cmd, hdr_dst, hdr_src, hdr_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [7:0]    drop_count;

  typedef struct {
    logic [2:0]  err;
    logic [31:0] hdr;
    int          nchk;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] hdr_m [4];
  logic [7:0] ref_mem [2**AW];
  int         exp_drop;
  int         errors;
  int         checks;

  maple_rx_frame_ctrl #(.MAX_WORDS(MAXW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rx_busy(rx_busy), .rx_write(rx_write), .rx_data(rx_data),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_err(frame_err),
    .hdr_cmd(hdr_cmd), .hdr_dst(hdr_dst), .hdr_src(hdr_src), .hdr_len(hdr_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xor_all();
    logic [7:0] x = 8'h00;
    foreach (tx_q[i]) x = x ^ tx_q[i];
    return x;
  endfunction

  // Drives tx_q as one frame; an accepted frame also updates the header and RAM model.
  task automatic send_frame(input bit accept, input bit fall_last, input bit drop_busy);
    int n = tx_q.size();
    @(negedge clk);
    rx_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rx_write = 1'b1;
      rx_data  = tx_q[i];
      if (fall_last && drop_busy && (i == n - 1)) rx_busy = 1'b0;
      @(negedge clk);
      rx_write = 1'b0;
    end
    if (drop_busy) rx_busy = 1'b0;
    if (accept) begin
      for (int i = 0; i < n && i < 4; i++) hdr_m[i] = tx_q[i];
      if (n >= 4 && tx_q[3] <= 8'(MAXW))
        for (int i = 0; i < 4 * int'(tx_q[3]) && i + 4 < n; i++) ref_mem[i] = tx_q[i + 4];
    end
  endtask

  task automatic push_exp(input logic [2:0] err, input int nchk);
    exp_t e;
    e.err  = err;
    e.hdr  = {hdr_m[0], hdr_m[1], hdr_m[2], hdr_m[3]};
    e.nchk = nchk;
    exp_q.push_back(e);
  endtask

  // Waits for a result, compares it with the scoreboard head, reads payload back and acks.
  task automatic collect(input bit lat_chk);
    exp_t e;
    int   n = 0;
    if (lat_chk) begin
      @(negedge clk);
      check_val("latency_early", 32'(frame_valid), 32'd0);
      @(negedge clk);
      check_val("latency_2cyc", 32'(frame_valid), 32'd1);
    end
    while (!frame_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("frame_valid", 32'(frame_valid), 32'd1);
    check_val("sb_pending", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("frame_err", 32'(frame_err), 32'(e.err));
      check_val("hdr", {hdr_cmd, hdr_dst, hdr_src, hdr_len}, e.hdr);
      check_val("drop_count", 32'(drop_count), 32'(exp_drop));
      for (int i = 0; i < e.nchk; i++) begin
        rd_addr = AW'(i);
        @(negedge clk);
        check_val($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(ref_mem[i]));
      end
      check_val("held_valid", 32'(frame_valid), 32'd1);
    end
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    check_val("ack_clears", 32'(frame_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0; checks = 0; exp_drop = 0;
    reset = 1'b0; rx_busy = 1'b0; rx_write = 1'b0; rx_data = 8'h00;
    frame_ack = 1'b0; rd_addr = '0;
    for (int i = 0; i < 4; i++) hdr_m[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_valid", 32'(frame_valid), 32'd0);
    check_val("rst_err", 32'(frame_err), 32'd0);
    check_val("rst_hdr", {hdr_cmd, hdr_dst, hdr_src, hdr_len}, 32'd0);
    check_val("rst_rd_data", 32'(rd_data), 32'd0);
    check_val("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Good one-word frame.
    tx_q = '{8'h01, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    tx_q.push_back(xor_all());
    send_frame(1'b1, 1'b0, 1'b1);
    push_exp(3'd0, 4);
    collect(1'b1);

    // Same frame with a corrupted CRC byte.
    tx_q = '{8'h01, 8'h20, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    tx_q.push_back(xor_all() ^ 8'h01);
    send_frame(1'b1, 1'b0, 1'b1);
    push_exp(3'd1, 4);
    collect(1'b0);

    // Two words announced, one word delivered.
    tx_q = '{8'h01, 8'h20, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(1'b1, 1'b0, 1'b1);
    push_exp(3'd2, 4);
    collect(1'b0);

    // Empty payload frame followed by one byte too many.
    tx_q = '{8'h01, 8'h20, 8'h00, 8'h00};
    tx_q.push_back(xor_all());
    tx_q.push_back(8'h5A);
    send_frame(1'b1, 1'b0, 1'b1);
    push_exp(3'd3, 0);
    collect(1'b0);

    // Length beyond MAX_WORDS; trailing bytes must not reach the RAM.
    tx_q = '{8'h01, 8'h20, 8'h00, 8'hFF, 8'h5A, 8'h6B, 8'h7C, 8'h8D};
    send_frame(1'b1, 1'b0, 1'b1);
    push_exp(3'd4, 4);
    collect(1'b0);

    // Two frames without ack: the second is dropped and the first result is held.
    tx_q = '{8'h02, 8'h21, 8'h03, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    tx_q.push_back(xor_all());
    send_frame(1'b1, 1'b0, 1'b1);
    push_exp(3'd0, 4);
    tx_q = '{8'h09, 8'h0A, 8'h0B, 8'h01, 8'h55, 8'h66, 8'h77, 8'h88};
    tx_q.push_back(xor_all());
    send_frame(1'b0, 1'b0, 1'b1);
    exp_drop++;
    collect(1'b0);

    // Third frame after the ack, CRC byte coinciding with rx_busy falling.
    tx_q = '{8'h01, 8'h20, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
             8'h12, 8'h34, 8'h56, 8'h78};
    tx_q.push_back(xor_all());
    send_frame(1'b1, 1'b1, 1'b1);
    push_exp(3'd0, 8);
    collect(1'b0);

    // Receiver stalls mid-header with rx_busy held high.
    tx_q = '{8'h03, 8'h07};
    send_frame(1'b1, 1'b0, 1'b0);
    push_exp(3'd5, 0);
    collect(1'b0);
    repeat (3) @(negedge clk);
    check_val("no_rearm_mid_frame", 32'(frame_valid), 32'd0);
    rx_busy = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a frame.
    rx_busy = 1'b1;
    @(negedge clk);
    rx_write = 1'b1; rx_data = 8'h9C;
    @(negedge clk);
    rx_write = 1'b0;
    reset = 1'b0;
    #1;
    check_val("midrst_hdr", {hdr_cmd, hdr_dst, hdr_src, hdr_len}, 32'd0);
    check_val("midrst_err", 32'(frame_err), 32'd0);
    check_val("midrst_drop", 32'(drop_count), 32'd0);
    rx_busy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_val("midrst_no_valid", 32'(frame_valid), 32'd0);
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
